// File: rtl/colorspace_pkg.sv
// Shared colour-space definitions for the luma pipeline: mode encodings,
// reference coefficients and width helpers.
package colorspace_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_601    = 2'd1,
        MODE_709    = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

    // Reference coefficients are expressed with 8 fractional bits (sum = 256).
    localparam int COEF_REF_FRAC = 8;
    localparam int C601_R8 = 77;
    localparam int C601_G8 = 150;
    localparam int C601_B8 = 29;
    localparam int C709_R8 = 54;
    localparam int C709_G8 = 183;
    localparam int C709_B8 = 19;

    // Rescale a reference coefficient to another fractional precision, rounding to nearest.
    function automatic int scale_coef(input int c8, input int frac);
        if (frac >= COEF_REF_FRAC)
            return c8 << (frac - COEF_REF_FRAC);
        return (c8 + (1 << (COEF_REF_FRAC - frac - 1))) >> (COEF_REF_FRAC - frac);
    endfunction

    function automatic int prod_width(input int sd, input int cw);
        return sd + cw;
    endfunction

    function automatic int sum_width(input int sd, input int cw);
        return sd + cw + 2;
    endfunction

endpackage

// File: rtl/luma_mac.sv
// One colour channel's registered multiply; loads a new product when I_EN is high.
module luma_mac #(
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_COEF_WIDTH     = 10
) (
    input  logic                                   I_CLK,
    input  logic                                   I_RESET,
    input  logic                                   I_EN,
    input  logic [P_SUBPIXEL_DEPTH-1:0]            I_CH,
    input  logic [P_COEF_WIDTH-1:0]                I_COEF,
    output logic [P_SUBPIXEL_DEPTH+P_COEF_WIDTH-1:0] O_PRODUCT
);

    localparam int PW = P_SUBPIXEL_DEPTH + P_COEF_WIDTH;

    always_ff @(posedge I_CLK) begin
        if (I_RESET)
            O_PRODUCT <= '0;
        else if (I_EN)
            O_PRODUCT <= PW'(I_CH) * PW'(I_COEF);
    end

endmodule

// File: rtl/luma_pipeline.sv
// Two-stage RGB-to-luma converter with selectable coefficients, rounding,
// saturation and valid/ready backpressure; luma is replicated onto R, G and B.
module luma_pipeline
    import colorspace_pkg::*;
#(
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_COEF_FRAC      = 8,
    parameter int P_COEF_WIDTH     = 10
) (
    input  logic                          I_CLK,
    input  logic                          I_RESET,
    input  logic                          I_ENABLE,
    input  logic [1:0]                    I_MODE,
    input  logic [P_COEF_WIDTH-1:0]       I_COEF_R,
    input  logic [P_COEF_WIDTH-1:0]       I_COEF_G,
    input  logic [P_COEF_WIDTH-1:0]       I_COEF_B,
    input  logic                          I_VALID,
    input  logic [3*P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
    output logic                          O_READY,
    output logic                          O_VALID,
    input  logic                          I_READY,
    output logic [3*P_SUBPIXEL_DEPTH-1:0] O_PIXEL
);

    localparam int SD    = P_SUBPIXEL_DEPTH;
    localparam int CW    = P_COEF_WIDTH;
    localparam int PW    = prod_width(SD, CW);
    localparam int SW    = sum_width(SD, CW);
    localparam int YW    = SW - P_COEF_FRAC;
    localparam int ROUND = 1 << (P_COEF_FRAC - 1);

    localparam logic [CW-1:0] K601_R = CW'(scale_coef(C601_R8, P_COEF_FRAC));
    localparam logic [CW-1:0] K601_G = CW'(scale_coef(C601_G8, P_COEF_FRAC));
    localparam logic [CW-1:0] K601_B = CW'(scale_coef(C601_B8, P_COEF_FRAC));
    localparam logic [CW-1:0] K709_R = CW'(scale_coef(C709_R8, P_COEF_FRAC));
    localparam logic [CW-1:0] K709_G = CW'(scale_coef(C709_G8, P_COEF_FRAC));
    localparam logic [CW-1:0] K709_B = CW'(scale_coef(C709_B8, P_COEF_FRAC));

    // Handshake: a pixel moves in when I_VALID & O_READY and out when O_VALID & I_READY.
    // The whole pipe shifts together on 'advance', so a stall holds both stages intact.
    logic advance;
    logic accept;
    assign advance = I_ENABLE & (~O_VALID | I_READY);
    assign O_READY = advance;
    assign accept  = I_VALID & advance;

    mode_e          in_mode;
    logic [CW-1:0]  coef_r, coef_g, coef_b;
    assign in_mode = mode_e'(I_MODE);

    always_comb begin
        coef_r = '0;
        coef_g = '0;
        coef_b = '0;
        case (in_mode)
            MODE_601:    begin coef_r = K601_R;   coef_g = K601_G;   coef_b = K601_B;   end
            MODE_709:    begin coef_r = K709_R;   coef_g = K709_G;   coef_b = K709_B;   end
            MODE_CUSTOM: begin coef_r = I_COEF_R; coef_g = I_COEF_G; coef_b = I_COEF_B; end
            default:     begin coef_r = '0;       coef_g = '0;       coef_b = '0;       end
        endcase
    end

    logic [PW-1:0] prod_r, prod_g, prod_b;

    luma_mac #(.P_SUBPIXEL_DEPTH(SD), .P_COEF_WIDTH(CW)) u_mac_r (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_EN(accept),
        .I_CH(I_PIXEL[3*SD-1:2*SD]), .I_COEF(coef_r), .O_PRODUCT(prod_r));
    luma_mac #(.P_SUBPIXEL_DEPTH(SD), .P_COEF_WIDTH(CW)) u_mac_g (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_EN(accept),
        .I_CH(I_PIXEL[2*SD-1:SD]), .I_COEF(coef_g), .O_PRODUCT(prod_g));
    luma_mac #(.P_SUBPIXEL_DEPTH(SD), .P_COEF_WIDTH(CW)) u_mac_b (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_EN(accept),
        .I_CH(I_PIXEL[SD-1:0]), .I_COEF(coef_b), .O_PRODUCT(prod_b));

    logic             s1_valid;
    mode_e            s1_mode;
    logic [3*SD-1:0]  s1_pixel;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_BYPASS;
            s1_pixel <= '0;
        end else if (advance) begin
            s1_valid <= I_VALID;
            if (I_VALID) begin
                s1_mode  <= in_mode;
                s1_pixel <= I_PIXEL;
            end
        end
    end

    logic [SW-1:0] sum;
    logic [YW-1:0] y_full;
    logic [SD-1:0] y_sat;

    always_comb begin
        sum    = SW'(prod_r) + SW'(prod_g) + SW'(prod_b) + SW'(ROUND);
        y_full = sum[SW-1:P_COEF_FRAC];
        y_sat  = (|y_full[YW-1:SD]) ? {SD{1'b1}} : y_full[SD-1:0];
    end

    // Bubbles clear O_VALID but leave the last emitted pixel on O_PIXEL.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_VALID <= 1'b0;
            O_PIXEL <= '0;
        end else if (advance) begin
            O_VALID <= s1_valid;
            if (s1_valid)
                O_PIXEL <= (s1_mode == MODE_BYPASS) ? s1_pixel : {3{y_sat}};
        end
    end

endmodule

// File: tb/tb_luma_pipeline.sv
// Directed bench for luma_pipeline: single-pixel vector table, mode switching,
// a backpressured stream against a golden model, and reset with pixels in flight.
module tb_luma_pipeline;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_ENABLE;
    logic [1:0]  I_MODE;
    logic [9:0]  I_COEF_R, I_COEF_G, I_COEF_B;
    logic        I_VALID;
    logic [23:0] I_PIXEL;
    logic        O_READY;
    logic        O_VALID;
    logic        I_READY;
    logic [23:0] O_PIXEL;

    int checks   = 0;
    int failures = 0;

    always #5 I_CLK = ~I_CLK;

    luma_pipeline #(.P_SUBPIXEL_DEPTH(8), .P_COEF_FRAC(8), .P_COEF_WIDTH(10)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE), .I_MODE(I_MODE),
        .I_COEF_R(I_COEF_R), .I_COEF_G(I_COEF_G), .I_COEF_B(I_COEF_B),
        .I_VALID(I_VALID), .I_PIXEL(I_PIXEL), .O_READY(O_READY), .O_VALID(O_VALID),
        .I_READY(I_READY), .O_PIXEL(O_PIXEL));

    typedef struct {
        logic [1:0]  mode;
        logic [9:0]  cr, cg, cb;
        logic [23:0] pixel;
        logic [23:0] exp_pix;
        string       name;
    } vec_t;

    vec_t vecs[10];
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] luma_model(input logic [1:0] m, input logic [23:0] p,
                                               input int cr, input int cg, input int cb);
        int kr, kg, kb, s, y;
        logic [7:0] y8;
        case (m)
            2'd1:    begin kr = 77; kg = 150; kb = 29; end
            2'd2:    begin kr = 54; kg = 183; kb = 19; end
            default: begin kr = cr; kg = cg; kb = cb; end
        endcase
        if (m == 2'd0) return p;
        s = int'(p[23:16]) * kr + int'(p[15:8]) * kg + int'(p[7:0]) * kb + 128;
        y = s >> 8;
        if (y > 255) y = 255;
        y8 = y[7:0];
        return {y8, y8, y8};
    endfunction

    // Present one pixel with I_READY high, check its value and accept->O_VALID latency.
    task automatic send_one(input logic [1:0] m, input logic [9:0] cr, input logic [9:0] cg,
                            input logic [9:0] cb, input logic [23:0] pix,
                            input logic [23:0] exp, input string name);
        int lat;
        int waits;
        @(negedge I_CLK);
        I_MODE = m; I_COEF_R = cr; I_COEF_G = cg; I_COEF_B = cb;
        I_PIXEL = pix; I_VALID = 1'b1; I_READY = 1'b1; I_ENABLE = 1'b1;
        #1;
        waits = 0;
        while (!O_READY && waits < 20) begin
            @(negedge I_CLK); #1; waits++;
        end
        if (!O_READY) begin
            check({name, "_accept_timeout"}, 32'(O_READY), 32'd1);
            I_VALID = 1'b0;
            return;
        end
        @(posedge I_CLK);
        lat = 1;
        @(negedge I_CLK);
        I_VALID = 1'b0;
        while (!O_VALID && lat < 10) begin
            @(posedge I_CLK); lat++; @(negedge I_CLK);
        end
        check({name, "_latency"}, 32'(lat), 32'd2);
        check(name, 32'(O_PIXEL), 32'(exp));
    endtask

    initial begin
        logic [1:0]  smode[8];
        logic [23:0] spix[8];
        int sent, recv;
        logic prev_stall;
        logic [23:0] prev_pix;

        vecs[0] = '{2'd1, 10'd0,   10'd0,   10'd0,   24'hFFFFFF, 24'hFFFFFF, "m601_white"};
        vecs[1] = '{2'd1, 10'd0,   10'd0,   10'd0,   24'hFF0000, 24'h4D4D4D, "m601_red"};
        vecs[2] = '{2'd1, 10'd0,   10'd0,   10'd0,   24'h0000FF, 24'h1D1D1D, "m601_blue"};
        vecs[3] = '{2'd2, 10'd0,   10'd0,   10'd0,   24'h00FF00, 24'hB6B6B6, "m709_green"};
        vecs[4] = '{2'd3, 10'd255, 10'd255, 10'd255, 24'hFFFFFF, 24'hFFFFFF, "custom_sat"};
        vecs[5] = '{2'd3, 10'd0,   10'd0,   10'd0,   24'hFFFFFF, 24'h000000, "custom_zero"};
        vecs[6] = '{2'd0, 10'd0,   10'd0,   10'd0,   24'h123456, 24'h123456, "bypass"};
        vecs[7] = '{2'd2, 10'd0,   10'd0,   10'd0,   24'hFFFFFF, 24'hFFFFFF, "m709_white"};
        vecs[8] = '{2'd3, 10'd128, 10'd64,  10'd32,  24'h102030, 24'h161616, "custom_mix"};
        vecs[9] = '{2'd1, 10'd0,   10'd0,   10'd0,   24'h808080, 24'h808080, "m601_grey"};

        I_RESET = 1'b1; I_ENABLE = 1'b1; I_MODE = 2'd0; I_VALID = 1'b0; I_READY = 1'b1;
        I_PIXEL = '0; I_COEF_R = '0; I_COEF_G = '0; I_COEF_B = '0;
        repeat (3) @(posedge I_CLK);
        @(negedge I_CLK);
        check("reset_o_valid", 32'(O_VALID), 32'd0);
        check("reset_o_pixel", 32'(O_PIXEL), 32'd0);
        check("reset_o_ready", 32'(O_READY), 32'd1);
        I_RESET = 1'b0;

        for (int i = 0; i < 10; i++)
            send_one(vecs[i].mode, vecs[i].cr, vecs[i].cg, vecs[i].cb,
                     vecs[i].pixel, vecs[i].exp_pix, vecs[i].name);

        // Back-to-back pixels with the mode switched from 601 to bypass in between.
        @(negedge I_CLK);
        I_MODE = 2'd1; I_PIXEL = 24'hFF0000; I_VALID = 1'b1; I_READY = 1'b1;
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_MODE = 2'd0; I_PIXEL = 24'h123456;
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_VALID = 1'b0; I_MODE = 2'd1;
        check("switch_first_valid", 32'(O_VALID), 32'd1);
        check("switch_first_pix", 32'(O_PIXEL), 32'h4D4D4D);
        @(posedge I_CLK);
        @(negedge I_CLK);
        check("switch_second_valid", 32'(O_VALID), 32'd1);
        check("switch_second_pix", 32'(O_PIXEL), 32'h123456);

        // Backpressured stream with a three-cycle enable hold.
        smode = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
        spix  = '{24'h102030, 24'hA0B0C0, 24'hFFFFFF, 24'hABCDEF,
                  24'h010203, 24'h405060, 24'hFF00FF, 24'h7F7F7F};
        sent = 0; recv = 0; prev_stall = 1'b0; prev_pix = '0;
        I_COEF_R = 10'd100; I_COEF_G = 10'd100; I_COEF_B = 10'd100;
        @(posedge I_CLK);
        for (int cyc = 0; cyc < 400 && recv < 8; cyc++) begin
            @(negedge I_CLK);
            if (prev_stall) begin
                check("stall_hold_valid", 32'(O_VALID), 32'd1);
                check("stall_hold_pix", 32'(O_PIXEL), 32'(prev_pix));
            end
            I_ENABLE = !(cyc >= 4 && cyc < 7);
            I_READY  = I_ENABLE ? 1'($urandom_range(0, 1)) : 1'b0;
            if (sent < 8) begin
                I_VALID = 1'b1; I_MODE = smode[sent]; I_PIXEL = spix[sent];
            end else begin
                I_VALID = 1'b0;
            end
            #1;
            if (!I_ENABLE) check("disabled_ready", 32'(O_READY), 32'd0);
            if (O_VALID && I_READY) begin
                if (exp_q.size() == 0) check("stream_extra_output", 32'(O_PIXEL), 32'hFFFFFFFF);
                else check("stream_pix", 32'(O_PIXEL), 32'(exp_q.pop_front()));
                recv++;
            end
            if (I_VALID && O_READY) begin
                exp_q.push_back(luma_model(I_MODE, I_PIXEL, 100, 100, 100));
                sent++;
            end
            prev_stall = O_VALID && !I_READY;
            prev_pix   = O_PIXEL;
        end
        check("stream_recv_count", 32'(recv), 32'd8);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two pixels in flight.
        @(negedge I_CLK);
        I_ENABLE = 1'b1; I_READY = 1'b1; I_VALID = 1'b1; I_MODE = 2'd1; I_PIXEL = 24'hFFFFFF;
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_PIXEL = 24'h0000FF;
        @(posedge I_CLK);
        @(negedge I_CLK);
        I_VALID = 1'b0;
        check("inflight_valid", 32'(O_VALID), 32'd1);
        I_RESET = 1'b1;
        @(posedge I_CLK);
        @(negedge I_CLK);
        check("midreset_o_valid", 32'(O_VALID), 32'd0);
        check("midreset_o_pixel", 32'(O_PIXEL), 32'd0);
        I_RESET = 1'b0;
        @(posedge I_CLK);
        @(negedge I_CLK);
        check("postreset_no_ghost", 32'(O_VALID), 32'd0);
        send_one(2'd1, 10'd0, 10'd0, 10'd0, 24'hFF0000, 24'h4D4D4D, "postreset_pix");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
